// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU: opcodes, FSM state type and flag values.
package mini_cpu_pkg;

   typedef enum logic [3:0] {
      OP_CLR = 4'h0,
      OP_LDI = 4'h1,
      OP_MOV = 4'h2,
      OP_ADD = 4'h3,
      OP_SUB = 4'h4,
      OP_SHL = 4'h5,
      OP_SHR = 4'h6,
      OP_AND = 4'h7,
      OP_OR  = 4'h8,
      OP_XOR = 4'h9,
      OP_CMP = 4'hA
   } opcode_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic FLAG_CLR = 1'b0;
   localparam logic FLAG_SET = 1'b1;

endpackage

// File: rtl/mini_cpu_alu.sv
// Combinational ALU for the single-cycle arithmetic, logic and compare ops.
module mini_cpu_alu
   import mini_cpu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  opcode_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             flag
);

   // Result and flag per opcode; non-ALU opcodes produce zero
   always_comb begin
      result = '0;
      flag   = FLAG_CLR;
      case (op)
         OP_ADD: {flag, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            result = a - b;
            flag   = (a < b) ? FLAG_SET : FLAG_CLR;
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_CMP: begin
            if (a > b)
               result = WIDTH'(1);
            else if (a == b)
               result = '0;
            else
               result = '1;
         end
         default: begin
            result = '0;
            flag   = FLAG_CLR;
         end
      endcase
   end

endmodule

// File: rtl/mini_cpu_param.sv
// Parameterised mini CPU: register file, result register and serial shift FSM.
module mini_cpu_param
   import mini_cpu_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NREGS = 4,
   localparam int RA    = $clog2(NREGS),
   localparam int IW    = 4 + 2*RA + WIDTH
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [IW-1:0]    In,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] Out,
   output logic             Overflow,
   output logic             Done,
   input  logic [RA-1:0]    RegSel,
   output logic [WIDTH-1:0] RegData
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];
   localparam logic [CW-1:0]    WIDTH_C = WIDTH[CW-1:0];

   state_t           state;
   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] rout;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_next;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    shamt;
   logic             shr_dir;
   logic             ovf;
   logic             done;

   opcode_t          op;
   logic [RA-1:0]    rd;
   logic [RA-1:0]    rs;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] alu_res;
   logic             alu_flag;

   assign op  = opcode_t'(In[IW-1 -: 4]);
   assign rd  = In[IW-5 -: RA];
   assign rs  = In[WIDTH+RA-1 -: RA];
   assign imm = In[WIDTH-1:0];

   mini_cpu_alu #(.WIDTH(WIDTH)) u_alu (
      .op     (op),
      .a      (regs[rd]),
      .b      (regs[rs]),
      .result (alu_res),
      .flag   (alu_flag)
   );

   // Shift amount saturated to WIDTH, and the next one-bit shift step
   always_comb begin
      shamt     = (imm >= WIDTH_V) ? WIDTH_C : imm[CW-1:0];
      work_next = shr_dir ? (work >> 1) : (work << 1);
   end

   // Instruction execution, register file and shift FSM
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int unsigned i = 0; i < NREGS; i++)
            regs[i] <= '0;
         rout    <= '0;
         work    <= '0;
         cnt     <= '0;
         shr_dir <= 1'b0;
         ovf     <= FLAG_CLR;
         done    <= FLAG_CLR;
         state   <= ST_IDLE;
      end else begin
         done <= FLAG_CLR;
         case (state)
            ST_IDLE: begin
               if (InValid) begin
                  done <= FLAG_SET;
                  case (op)
                     OP_CLR: begin
                        for (int unsigned i = 0; i < NREGS; i++)
                           regs[i] <= '0;
                        rout <= '0;
                        ovf  <= FLAG_CLR;
                     end
                     OP_LDI: regs[rd] <= imm;
                     OP_MOV: regs[rd] <= rout;
                     OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                        rout <= alu_res;
                        ovf  <= alu_flag;
                     end
                     OP_SHL, OP_SHR: begin
                        ovf <= FLAG_CLR;
                        if (shamt == '0) begin
                           rout <= regs[rd];
                        end else begin
                           // Multi-cycle: the completion pulse comes from SHIFT instead
                           done    <= FLAG_CLR;
                           work    <= regs[rd];
                           cnt     <= shamt;
                           shr_dir <= (op == OP_SHR);
                           state   <= ST_SHIFT;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_SHIFT: begin
               work <= work_next;
               cnt  <= cnt - CW'(1);
               if (!shr_dir)
                  ovf <= ovf | work[WIDTH-1];
               if (cnt == CW'(1)) begin
                  rout  <= work_next;
                  done  <= FLAG_SET;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign InReady  = (state == ST_IDLE);
   assign Out      = rout;
   assign Overflow = ovf;
   assign Done     = done;
   assign RegData  = regs[RegSel];

endmodule

// File: tb/tb_mini_cpu_param.sv
// Self-checking bench for mini_cpu_param (WIDTH=8, NREGS=4) with a reference model.
module tb_mini_cpu_param;

   logic        Clock;
   logic        Reset;
   logic [15:0] In;
   logic        InValid;
   logic        InReady;
   logic [7:0]  Out;
   logic        Overflow;
   logic        Done;
   logic [1:0]  RegSel;
   logic [7:0]  RegData;

   int tests = 0;
   int fails = 0;

   // Reference state
   int unsigned mr [4];
   int unsigned mout;
   int unsigned movf;

   mini_cpu_param #(.WIDTH(8), .NREGS(4)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .In       (In),
      .InValid  (InValid),
      .InReady  (InReady),
      .Out      (Out),
      .Overflow (Overflow),
      .Done     (Done),
      .RegSel   (RegSel),
      .RegData  (RegData)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
      return {op[3:0], rd[1:0], rs[1:0], imm[7:0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mr[i] = 0;
      mout = 0;
      movf = 0;
   endtask

   // Architectural effect of one instruction; lat = clock edges from acceptance to Rout update
   task automatic model_apply(input int op, input int rd, input int rs, input int imm, output int lat);
      int unsigned a, b, s, c;
      longint unsigned v;
      a = mr[rd];
      b = mr[rs];
      lat = 0;
      case (op)
         0: model_reset();
         1: mr[rd] = imm;
         2: mr[rd] = mout;
         3: begin s = a + b; mout = s % 256; movf = (s > 255) ? 1 : 0; end
         4: begin mout = (a + 256 - b) % 256; movf = (a < b) ? 1 : 0; end
         5: begin
            c = (imm > 8) ? 8 : imm;
            v = longint'(a) * (longint'(1) << c);
            mout = int'(v % 256);
            movf = ((v / 256) != 0) ? 1 : 0;
            lat = c;
         end
         6: begin
            c = (imm > 8) ? 8 : imm;
            mout = a / (1 << c);
            movf = 0;
            lat = c;
         end
         7: begin mout = a & b; movf = 0; end
         8: begin mout = a | b; movf = 0; end
         9: begin mout = a ^ b; movf = 0; end
         10: begin mout = (a > b) ? 1 : ((a == b) ? 0 : 255); movf = 0; end
         default: ;
      endcase
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         RegSel = i[1:0];
         #1;
         check(tag, RegData, mr[i]);
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, "_out"}, Out, mout);
      check({tag, "_ovf"}, Overflow, movf);
   endtask

   // Issue one instruction, wait for its Done pulse (bounded) and check everything
   task automatic issue(input int op, input int rd, input int rs, input int imm);
      int lat;
      int n;
      bit bad_ready;
      model_apply(op, rd, rs, imm, lat);
      check("ready_before", InReady, 1);
      In = enc(op, rd, rs, imm);
      InValid = 1'b1;
      @(posedge Clock); #1;
      // A CLR held valid while busy must be ignored until IDLE
      if (lat > 0) In = enc(0, 0, 0, 0);
      else InValid = 1'b0;
      n = 0;
      bad_ready = 1'b0;
      while (Done !== 1'b1 && n < 40) begin
         if (InReady !== 1'b0) bad_ready = 1'b1;
         @(posedge Clock); #1;
         n++;
      end
      InValid = 1'b0;
      check("latency", n, lat);
      check("ready_low_while_shifting", bad_ready, 0);
      check("ready_after", InReady, 1);
      check_outs("result");
      check_regs("regfile");
      @(posedge Clock); #1;
      check("done_single_pulse", Done, 0);
   endtask

   initial begin
      int lat;
      int op, imm;
      bit seen;
      In = '0;
      InValid = 1'b0;
      RegSel = '0;
      Reset = 1'b1;
      model_reset();
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      check("reset_ready", InReady, 1);
      check("reset_done", Done, 0);
      check_outs("reset");
      check_regs("reset_regs");

      // Carry out of ADD, then compare less-than
      issue(1, 0, 0, 8'h80);
      issue(1, 1, 0, 8'h82);
      issue(3, 0, 1, 0);
      check("add_const_out", Out, 8'h02);
      check("add_const_ovf", Overflow, 1);
      issue(10, 0, 1, 0);
      check("cmp_lt_const", Out, 8'hFF);

      // Compare greater-than and MOV of Rout
      issue(1, 2, 0, 8'h20);
      issue(1, 3, 0, 8'h00);
      issue(10, 2, 3, 0);
      check("cmp_gt_const", Out, 8'h01);
      issue(2, 3, 0, 0);
      RegSel = 2'd3; #1;
      check("mov_const", RegData, 8'h01);

      // Serial shifts, including saturation, zero count and rd == rs
      issue(1, 0, 0, 8'h41);
      issue(5, 0, 0, 3);
      check("shl3_const_out", Out, 8'h08);
      check("shl3_const_ovf", Overflow, 1);
      issue(6, 0, 0, 9);
      check("shr9_const", Out, 8'h00);
      issue(5, 0, 0, 0);
      issue(5, 0, 0, 8);
      issue(6, 0, 0, 1);
      issue(4, 2, 2, 0);
      issue(11, 1, 2, 8'h5A);

      // Borrow from SUB, then CLR
      issue(1, 0, 0, 8'h01);
      issue(1, 1, 0, 8'h00);
      issue(4, 1, 0, 0);
      check("sub_const_out", Out, 8'hFF);
      check("sub_const_ovf", Overflow, 1);
      issue(0, 0, 0, 0);

      // Reset in the second SHIFT cycle aborts the shift
      issue(1, 0, 0, 8'h41);
      issue(1, 1, 0, 8'h33);
      issue(3, 0, 1, 0);
      In = enc(5, 0, 0, 5);
      InValid = 1'b1;
      @(posedge Clock); #1;
      InValid = 1'b0;
      check("abort_busy", InReady, 0);
      @(posedge Clock); #1;
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      model_reset();
      check("abort_ready", InReady, 1);
      check("abort_done", Done, 0);
      check_outs("abort");
      check_regs("abort_regs");
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge Clock); #1;
         if (Done === 1'b1) seen = 1'b1;
      end
      check("abort_no_done", seen, 0);
      check_outs("abort_later");

      // Reset wins over an instruction in the same cycle
      Reset = 1'b1;
      In = enc(1, 2, 0, 8'h55);
      InValid = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      InValid = 1'b0;
      check_regs("reset_over_ldi");

      // Four back-to-back single-cycle ops
      begin
         int bops [4] = '{1, 1, 3, 9};
         int brd  [4] = '{0, 1, 0, 0};
         int brs  [4] = '{0, 0, 1, 1};
         int bimm [4] = '{8'hF0, 8'h25, 0, 0};
         In = enc(bops[0], brd[0], brs[0], bimm[0]);
         InValid = 1'b1;
         for (int k = 0; k < 4; k++) begin
            check("b2b_ready", InReady, 1);
            @(posedge Clock); #1;
            model_apply(bops[k], brd[k], brs[k], bimm[k], lat);
            check("b2b_done", Done, 1);
            check_outs("b2b");
            if (k < 3) In = enc(bops[k+1], brd[k+1], brs[k+1], bimm[k+1]);
            else InValid = 1'b0;
         end
         @(posedge Clock); #1;
         check("b2b_done_end", Done, 0);
         check_regs("b2b_regs");
      end

      // Randomized instruction stream with idle gaps carrying junk
      repeat (80) begin
         if ($urandom_range(0, 4) == 0) begin
            In = 16'($urandom);
            InValid = 1'b0;
            @(posedge Clock); #1;
            check("idle_no_done", Done, 0);
            check_outs("idle");
         end
         op = int'($urandom_range(0, 15));
         if (op == 0 && $urandom_range(0, 3) != 0) op = 3;
         if ($urandom_range(0, 3) == 0) op = 1;
         imm = (op == 5 || op == 6) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
         issue(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), imm);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mini_cpu_param.md
MINI_CPU_PARAM -- requirements
Module: mini_cpu_param

Interface
REQ-001 Parameter WIDTH, default 8: data/register width in bits; legal values are 4 to 32.
REQ-002 Parameter NREGS, default 4: register-file depth; power of two, at least 2; RA = log2(NREGS).
REQ-003 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  reset is synchronous and active-high.
REQ-005 In  input  4+2*RA+WIDTH  instruction {op[3:0], rd[RA-1:0], rs[RA-1:0], imm[WIDTH-1:0]}.
REQ-006 InValid  input  1  In holds a valid instruction.
REQ-007 InReady  output  1  block can accept an instruction this cycle.
REQ-008 Out  output  WIDTH  result register Rout.
REQ-009 Overflow  output  1  flag from the last completed ALU or shift operation.
REQ-010 Done  output  1  one-cycle pulse in the cycle after any instruction completes.
REQ-011 RegSel  input  RA  debug read select.
REQ-012 RegData  output  WIDTH  combinational R[RegSel].

Function
REQ-013 Handshake: an instruction is accepted on a rising edge where InValid and InReady are both 1; In is ignored at all other times.
REQ-014 FSM states are IDLE and SHIFT; InReady = 1 only in IDLE.
REQ-015 Op 0000 CLR: all R[i], Rout and Overflow go to 0.
REQ-016 Op 0001 LDI: R[rd] = imm; Rout and Overflow hold.
REQ-017 Op 0010 MOV: R[rd] = Rout; Rout and Overflow hold.
REQ-018 Op 0011 ADD: Rout = (R[rd]+R[rs]) mod 2^WIDTH; Overflow = carry-out.
REQ-019 Op 0100 SUB: Rout = (R[rd]-R[rs]) mod 2^WIDTH; Overflow = borrow (R[rd] < R[rs], unsigned).
REQ-020 Ops 0111 AND, 1000 OR, 1001 XOR: Rout = R[rd] op R[rs]; Overflow = 0.
REQ-021 Op 1010 CMP (unsigned): Rout = 1 if R[rd] > R[rs], 0 if equal, all-ones if less; Overflow = 0.
REQ-022 Ops 1011 to 1111: no-op; Done still pulses.
REQ-023 Single-cycle ops (all except SHL/SHR): registers update at the accepting edge; Done = 1 in the following cycle; FSM stays in IDLE.
REQ-024 Op 0101 SHL / 0110 SHR: shift R[rd] logically by c = imm, saturated to WIDTH.
REQ-025 Shift with c = 0: completes like a single-cycle op; Rout = R[rd]; Overflow = 0.
REQ-026 Shift with c > 0: at acceptance, load a working copy of R[rd], load a counter with c, clear Overflow and enter SHIFT.
REQ-027 In SHIFT: shift one bit per cycle and decrement the counter; on the edge where the counter reaches 0, write Rout and return to IDLE.
REQ-028 Shift latency: c cycles from acceptance to Rout update; Done = 1 the cycle after.
REQ-029 SHL Overflow = OR of all bits shifted out; SHR Overflow = 0.
REQ-030 Rout holds its previous value during SHIFT; the register file is never modified by a shift.
REQ-031 rd == rs is legal and uses the same value for both operands (e.g. SUB gives 0).
REQ-032 Back-to-back single-cycle instructions are accepted every cycle with no bubble.

Reset
REQ-033 While Reset = 1 on an edge: all R[i], Rout, Overflow, the shift counter and Done go to 0, and the FSM goes to IDLE.
REQ-034 Reset overrides any instruction presented in the same cycle.
REQ-035 Reset during SHIFT aborts the operation; no Rout write and no Done pulse.
REQ-036 After reset, InReady = 1 in the first cycle in which Reset = 0.

Structure
REQ-037 Package mini_cpu_pkg holds the opcode constants, the FSM state type and the Done/Overflow flag encoding.
REQ-038 Sub-module mini_cpu_alu: combinational ADD/SUB/AND/OR/XOR/CMP; inputs are two WIDTH operands and op; outputs are the result and the flag.
REQ-039 The register file and shift FSM stay in mini_cpu_param.

Verification (WIDTH=8, NREGS=4)
REQ-040 LDI R0=0x80, LDI R1=0x82, ADD R0,R1 -> Out=0x02, Overflow=1; CMP R0,R1 -> Out=0xFF.
REQ-041 LDI R2=0x20, LDI R3=0x00, CMP R2,R3 -> Out=0x01; MOV R3 -> R3=0x01 on RegData.
REQ-042 LDI R0=0x41, SHL R0 by 3 -> InReady low for 3 cycles, Out=0x08, Overflow=1, Done 1 cycle later; SHR by 9 saturates to 8 -> Out=0x00.
REQ-043 Reset asserted on the 2nd SHIFT cycle -> Out=0, all registers 0, no Done, InReady=1 next cycle.
REQ-044 LDI R0=0x01, SUB R1,R0 with R1=0 -> Out=0xFF, Overflow=1; CLR -> all 0.
REQ-045 Four single-cycle ops held valid on consecutive cycles -> four Done pulses on consecutive cycles, InReady constantly 1.
